lcd_nibble_writer: RTL

//  HD44780 4-bit-bus write engine. Sits downstream of the time/text formatter and owns the LCD pins.

---
 rtl/lcd_pkg.sv | 62 ++++++
 rtl/lcd_delay_timer.sv | 28 ++
 rtl/lcd_nibble_writer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared definitions for the HD44780 4-bit write engine.
//  - FSM state encoding
//  - HD44780 command byte constants
//  - power-on init list (8-entry constant ROM of {is_nibble, value, long_wait})
//  - small helpers for timer sizing and wait selection
package lcd_pkg;

  typedef enum logic [2:0] {
    PWRUP = 3'd0,
    SETUP = 3'd1,
    EN_HI = 3'd2,
    EN_LO = 3'd3,
    EXEC  = 3'd4,
    IDLE  = 3'd5
  } lcd_state_e;

  localparam logic [7:0] LCD_CLEAR     = 8'h01;
  localparam logic [7:0] LCD_HOME      = 8'h02;
  localparam logic [7:0] LCD_FUNC_4B2L = 8'h28;
  localparam logic [7:0] LCD_DISP_ON   = 8'h0C;
  localparam logic [7:0] LCD_ENTRY_INC = 8'h06;
  localparam logic [7:0] LCD_LINE1     = 8'h80;
  localparam logic [7:0] LCD_LINE2     = 8'hC0;

  // One init step. A nibble item sends only value[7:4] (one strobe);
  // a byte item sends value[7:4] then value[3:0].
  typedef struct packed {
    logic       is_nibble;
    logic [7:0] value;
    logic       long_wait;
  } init_item_t;

  localparam int          INIT_LEN  = 8;
  localparam logic [2:0]  INIT_LAST = 3'(INIT_LEN - 1);

  // Init ROM: wake-up nibbles 3,3,3 then switch to 4-bit mode (2),
  // followed by function set, display on, entry mode, clear.
  function automatic init_item_t init_rom(input logic [2:0] idx);
    init_item_t it;
    case (idx)
      3'd0:    it = '{is_nibble: 1'b1, value: 8'h30,         long_wait: 1'b1};
      3'd1:    it = '{is_nibble: 1'b1, value: 8'h30,         long_wait: 1'b0};
      3'd2:    it = '{is_nibble: 1'b1, value: 8'h30,         long_wait: 1'b0};
      3'd3:    it = '{is_nibble: 1'b1, value: 8'h20,         long_wait: 1'b0};
      3'd4:    it = '{is_nibble: 1'b0, value: LCD_FUNC_4B2L, long_wait: 1'b0};
      3'd5:    it = '{is_nibble: 1'b0, value: LCD_DISP_ON,   long_wait: 1'b0};
      3'd6:    it = '{is_nibble: 1'b0, value: LCD_ENTRY_INC, long_wait: 1'b0};
      default: it = '{is_nibble: 1'b0, value: LCD_CLEAR,     long_wait: 1'b1};
    endcase
    return it;
  endfunction

  // Clear and home are the only commands needing the long execution wait.
  function automatic logic is_long_cmd(input logic rs_i, input logic [7:0] b);
    return !rs_i && (b == LCD_CLEAR || b == LCD_HOME);
  endfunction

  function automatic int cmax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// lcd_delay_timer: single down-counter shared by every timed FSM state.
//  clk, rst   : clock, synchronous active-high reset (counter reloads RST_VAL)
//  load       : load load_val this cycle (state entry, value = N-1)
//  load_val   : reload value
//  expired    : counter is at zero; a state lasting N cycles exits here
// The counter parks at zero, so an untimed state never wraps it.
module lcd_delay_timer #(
  parameter int             W       = 8,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)              cnt <= RST_VAL;
    else if (load)        cnt <= load_val;
    else if (cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/lcd_nibble_writer.sv
// lcd_nibble_writer: HD44780 4-bit-bus write engine. Owns the LCD pins,
// runs the power-on init list, then sends (rs, byte) pairs as two
// enable-strobed nibbles each followed by the command execution wait.
//  clk        : system clock
//  rst        : synchronous active-high reset; restarts from PWRUP
//  in_valid   : byte request valid
//  in_rs      : 0 = command, 1 = data
//  in_byte    : byte to write
//  in_ready   : idle and initialised; transfer on in_valid & in_ready
//  init_done  : init list complete; sticky until rst
//  rs, en     : LCD register select / enable strobe
//  data       : LCD D7..D4
module lcd_nibble_writer
  import lcd_pkg::*;
#(
  parameter int POWERUP_CYC   = 180000,
  parameter int EN_HIGH_CYC   = 800,
  parameter int EN_LOW_CYC    = 800,
  parameter int CMD_WAIT_CYC  = 600,
  parameter int LONG_WAIT_CYC = 24000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_rs,
  input  logic [7:0] in_byte,
  output logic       in_ready,
  output logic       init_done,
  output logic       rs,
  output logic       en,
  output logic [3:0] data
);

  localparam int MAX_CYC = cmax(cmax(POWERUP_CYC, EN_HIGH_CYC),
                                cmax(EN_LOW_CYC, cmax(CMD_WAIT_CYC, LONG_WAIT_CYC)));
  localparam int TW = $clog2(MAX_CYC + 1);

  // Timer reload values are N-1: the state entry cycle counts as one.
  localparam logic [TW-1:0] T_PWR = TW'(POWERUP_CYC - 1);
  localparam logic [TW-1:0] T_ENH = TW'(EN_HIGH_CYC - 1);
  localparam logic [TW-1:0] T_ENL = TW'(EN_LOW_CYC - 1);
  localparam logic [TW-1:0] T_CMD = TW'(CMD_WAIT_CYC - 1);
  localparam logic [TW-1:0] T_LNG = TW'(LONG_WAIT_CYC - 1);

  lcd_state_e state, state_n;

  logic [2:0] item_idx;
  logic [3:0] cur_lo;     // low nibble waiting for its strobe
  logic       cur_nib;    // current item is a single nibble (init only)
  logic       cur_long;   // current item needs the long execution wait
  logic       lo_phase;   // low nibble is the one on the bus

  logic          tmr_load, tmr_exp;
  logic [TW-1:0] tmr_val;

  logic       start_item, start_byte, start_lo, adv_idx, finish_init;
  logic [2:0] rom_idx;
  init_item_t rom_item;

  lcd_delay_timer #(.W(TW), .RST_VAL(T_PWR)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_exp)
  );

  assign in_ready = (state == IDLE) && init_done;
  assign en       = (state == EN_HI);

  // Next init item is fetched from PWRUP (index 0) or from EXEC (index+1).
  assign rom_idx  = adv_idx ? item_idx + 3'd1 : item_idx;
  assign rom_item = init_rom(rom_idx);

  always_comb begin
    state_n     = state;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    start_item  = 1'b0;
    start_byte  = 1'b0;
    start_lo    = 1'b0;
    adv_idx     = 1'b0;
    finish_init = 1'b0;
    case (state)
      PWRUP: if (tmr_exp) begin
        state_n    = SETUP;
        start_item = 1'b1;
      end
      // Address setup is a fixed single cycle; no timer needed.
      SETUP: begin
        state_n  = EN_HI;
        tmr_load = 1'b1;
        tmr_val  = T_ENH;
      end
      EN_HI: if (tmr_exp) begin
        state_n  = EN_LO;
        tmr_load = 1'b1;
        tmr_val  = T_ENL;
      end
      EN_LO: if (tmr_exp) begin
        if (!lo_phase && !cur_nib) begin
          state_n  = SETUP;
          start_lo = 1'b1;
        end else begin
          state_n  = EXEC;
          tmr_load = 1'b1;
          tmr_val  = cur_long ? T_LNG : T_CMD;
        end
      end
      EXEC: if (tmr_exp) begin
        if (init_done) begin
          state_n = IDLE;
        end else if (item_idx == INIT_LAST) begin
          state_n     = IDLE;
          finish_init = 1'b1;
        end else begin
          state_n    = SETUP;
          start_item = 1'b1;
          adv_idx    = 1'b1;
        end
      end
      IDLE: if (in_valid && in_ready) begin
        state_n    = SETUP;
        start_byte = 1'b1;
      end
      default: state_n = PWRUP;
    endcase
  end

  // rs/data are only ever loaded on SETUP entry, so they are frozen
  // through EN_HI and EN_LO by construction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= PWRUP;
      item_idx  <= '0;
      cur_lo    <= '0;
      cur_nib   <= 1'b0;
      cur_long  <= 1'b0;
      lo_phase  <= 1'b0;
      rs        <= 1'b0;
      data      <= '0;
      init_done <= 1'b0;
    end else begin
      state <= state_n;
      if (adv_idx) item_idx <= item_idx + 3'd1;
      if (start_item) begin
        cur_lo   <= rom_item.value[3:0];
        cur_nib  <= rom_item.is_nibble;
        cur_long <= rom_item.long_wait;
        lo_phase <= 1'b0;
        rs       <= 1'b0;
        data     <= rom_item.value[7:4];
      end
      if (start_byte) begin
        cur_lo   <= in_byte[3:0];
        cur_nib  <= 1'b0;
        cur_long <= is_long_cmd(in_rs, in_byte);
        lo_phase <= 1'b0;
        rs       <= in_rs;
        data     <= in_byte[7:4];
      end
      if (start_lo) begin
        lo_phase <= 1'b1;
        data     <= cur_lo;
      end
      if (finish_init) init_done <= 1'b1;
    end
  end

endmodule
